// File: rtl/counter_sched.sv
// Round-robin sharing of one external loadable up-counter between N requesters.
// The winner's start value is loaded into the counter; when the counter reaches
// TERM the owner gets a one-cycle done pulse. Dropping req while running aborts
// the interval without a done.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests from the RR pointer upward
// LOAD  | owner latched; drive ctr_load for one cycle with the owner's value
// RUN   | wait for ctr_count == TERM; owner dropping req aborts
// DONE  | pulse done to the owner, advance the RR pointer past it
module counter_sched #(
  parameter int            N    = 4,
  parameter int            W    = 4,
  parameter logic [W-1:0]  TERM = {W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   req_value,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     done,
  output logic             busy,
  output logic             ctr_load,
  output logic [W-1:0]     ctr_init,
  input  logic [W-1:0]     ctr_count
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    init_q, init_d;
  logic [SW-1:0]   pick;
  logic            found;
  logic [SW-1:0]   sel_inc;
  logic [2*N-1:0]  req_rot;
  logic [N-1:0]    sel_onehot;
  int              pos;

  // Rotate requests so bit 0 is the pointer position, then take the first set bit.
  always_comb begin
    req_rot = {req, req} >> ptr_q;
    pick    = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pos   = int'(ptr_q) + k;
        if (pos >= N) pos = pos - N;
        pick  = SW'(pos);
      end
    end
  end

  // Pointer moves one past the owner so it has lowest priority next round.
  always_comb begin
    sel_inc = (sel_q == SW'(N - 1)) ? '0 : sel_q + SW'(1);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    init_d  = init_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          init_d  = req_value[pick*W +: W];
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // Abort wins over reaching TERM in the same cycle.
        if (!req[sel_q]) begin
          ptr_d   = sel_inc;
          state_d = IDLE;
        end else if (ctr_count == TERM) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = sel_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any interval in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      init_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      init_q  <= init_d;
    end
  end

  // Outputs decoded only from registered state.
  always_comb begin
    sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel_q;
    grant      = (state_q != IDLE) ? sel_onehot : '0;
    done       = (state_q == DONE) ? sel_onehot : '0;
    busy       = (state_q != IDLE);
    ctr_load   = (state_q == LOAD);
    ctr_init   = init_q;
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: a behavioural external counter is attached
// to each instance; cycle 0 is the IDLE cycle in which a request is first seen.
module tb_counter_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_value = '0;
  logic [3:0]  grant, done, ctr_init;
  logic        busy, ctr_load;
  logic [3:0]  cnt = '0;

  logic [3:0]  req2 = '0;
  logic [15:0] req_value2 = '0;
  logic [3:0]  grant2, done2, ctr_init2;
  logic        busy2, ctr_load2;
  logic [3:0]  cnt2 = '0;

  int checks = 0;
  int fails  = 0;

  counter_sched #(.N(4), .W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_value(req_value),
    .grant(grant), .done(done), .busy(busy), .ctr_load(ctr_load),
    .ctr_init(ctr_init), .ctr_count(cnt)
  );

  counter_sched #(.N(4), .W(4), .TERM(4'h2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_value(req_value2),
    .grant(grant2), .done(done2), .busy(busy2), .ctr_load(ctr_load2),
    .ctr_init(ctr_init2), .ctr_count(cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cnt  <= ctr_load  ? ctr_init  : cnt  + 4'd1;
    cnt2 <= ctr_load2 ? ctr_init2 : cnt2 + 4'd1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    req  = '0;
    req2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'hF;
    req_value = 16'h1234;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'h0)    begin fails++; $display("FAIL reset_grant: got %h expected 0", grant); end
    checks++; if (done !== 4'h0)     begin fails++; $display("FAIL reset_done: got %h expected 0", done); end
    checks++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ctr_load !== 1'b0) begin fails++; $display("FAIL reset_load: got %b expected 0", ctr_load); end
    checks++; if (ctr_init !== 4'h0) begin fails++; $display("FAIL reset_init: got %h expected 0", ctr_init); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin fails++; $display("FAIL reset_first_grant: got %b expected 0001", grant); end
    checks++; if (ctr_load !== 1'b1) begin fails++; $display("FAIL reset_first_load: got %b expected 1", ctr_load); end
    req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    req_value = 16'h0004;
    @(negedge clk);
    checks++; if (ctr_load !== 1'b1) begin fails++; $display("FAIL single_load: got %b expected 1", ctr_load); end
    checks++; if (ctr_init !== 4'h4) begin fails++; $display("FAIL single_init: got %h expected 4", ctr_init); end
    checks++; if (grant !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b expected 0001", grant); end
    for (int c = 2; c <= 15; c++) begin
      @(negedge clk);
      if (c <= 14) begin
        checks++;
        if (done !== ((c == 14) ? 4'b0001 : 4'b0000)) begin
          fails++; $display("FAIL single_done c%0d: got %b expected %b", c, done, (c == 14) ? 4'b0001 : 4'b0000);
        end
      end
      if (c == 14) req = '0;
      if (c == 15) begin
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b expected 0", busy); end
      end
    end
  endtask

  task automatic test_round_robin();
    int         exp_order [4] = '{0, 1, 3, 0};
    int         ng = 0;
    int         nd = 0;
    int         gcyc = 0;
    logic [3:0] prev_g = '0;
    logic [3:0] eg;
    do_reset();
    req = 4'b1011;
    req_value = 16'hEEEE;
    for (int c = 1; c <= 40 && nd < 4; c++) begin
      @(negedge clk);
      if (grant !== 4'h0 && prev_g === 4'h0 && ng < 4) begin
        eg = 4'b0001 << exp_order[ng];
        checks++;
        if (grant !== eg) begin fails++; $display("FAIL rr_grant_%0d: got %b expected %b", ng, grant, eg); end
        gcyc = c;
        ng++;
      end
      if (done !== 4'h0) begin
        checks++;
        if (done !== prev_g || c != gcyc + 3) begin
          fails++; $display("FAIL rr_done_%0d: got %b at c%0d expected %b at c%0d", nd, done, c, prev_g, gcyc + 3);
        end
        nd++;
        if (nd == 4) req = '0;
      end
      prev_g = grant;
    end
    checks++; if (nd != 4) begin fails++; $display("FAIL rr_done_count: got %0d expected 4", nd); end
    req = '0;
  endtask

  task automatic test_edge_values();
    logic [3:0] e1, e2;
    do_reset();
    req = 4'b0001;  req_value = 16'h000F;
    req2 = 4'b0001; req_value2 = 16'h000E;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      e1 = (c == 3) ? 4'b0001 : 4'b0000;
      e2 = (c == 7) ? 4'b0001 : 4'b0000;
      checks++; if (done !== e1)  begin fails++; $display("FAIL edge_f_done c%0d: got %b expected %b", c, done, e1); end
      checks++; if (done2 !== e2) begin fails++; $display("FAIL edge_wrap_done c%0d: got %b expected %b", c, done2, e2); end
      if (c == 6) begin
        checks++; if (cnt2 !== 4'h2) begin fails++; $display("FAIL edge_wrap_count: got %h expected 2", cnt2); end
      end
      if (c == 3) req = '0;
      if (c == 7) req2 = '0;
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b1100;
    req_value = 16'hD000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (done !== 4'h0) begin fails++; $display("FAIL abort_done c%0d: got %b expected 0000", c, done); end
      if (c == 1 || c == 6) begin
        checks++; if (grant !== 4'b0100) begin fails++; $display("FAIL abort_grant c%0d: got %b expected 0100", c, grant); end
      end
      if (c == 6) req = 4'b1000;
      if (c == 7) begin
        checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL abort_grant_drop: got %b expected 0000", grant); end
      end
      if (c == 8) begin
        checks++; if (grant !== 4'b1000) begin fails++; $display("FAIL abort_next_grant: got %b expected 1000", grant); end
      end
    end
    req = '0;
    // Drop coinciding with TERM: abort wins, no done.
    do_reset();
    req = 4'b0001;
    req_value = 16'h000F;
    repeat (2) @(negedge clk);
    req = '0;
    @(negedge clk);
    checks++; if (done !== 4'h0)  begin fails++; $display("FAIL abort_at_term_done: got %b expected 0000", done); end
    checks++; if (grant !== 4'h0) begin fails++; $display("FAIL abort_at_term_grant: got %b expected 0000", grant); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req = 4'b0010;
    req_value = 16'h00F0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 4'b0010) begin fails++; $display("FAIL midrst_first_done: got %b expected 0010", done); end
    req = 4'b1000;
    req_value = 16'h5000;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (grant !== 4'h0)    begin fails++; $display("FAIL midrst_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0)     begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 4'h0)     begin fails++; $display("FAIL midrst_done: got %b expected 0000", done); end
    checks++; if (ctr_load !== 1'b0) begin fails++; $display("FAIL midrst_load: got %b expected 0", ctr_load); end
    checks++; if (ctr_init !== 4'h0) begin fails++; $display("FAIL midrst_init: got %h expected 0", ctr_init); end
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1011;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin fails++; $display("FAIL midrst_ptr: got %b expected 0001", grant); end
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      checks++; if (done !== 4'h0) begin fails++; $display("FAIL midrst_no_done c%0d: got %b expected 0000", c, done); end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_edge_values();
    test_abort();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
